// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the data-memory store logger.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Byte-offset bits inside a 32-bit word.
    localparam int WORD_OFFSET_BITS = 2;

    // One recorded store: byte address and the data written.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    // A store is word-aligned when its byte-offset bits are zero.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[WORD_OFFSET_BITS-1:0] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrlog_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wrlog_fifo
// Description : Store-log FIFO. A push into a full FIFO is dropped unless a
//               pop happens in the same cycle; a dropped push pulses overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module wrlog_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  log_entry_t             push_entry,
    input  logic                   pop,
    output log_entry_t             head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);

    log_entry_t     mem_q [DEPTH];
    log_entry_t     mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (count_q == (AW+1)'(DEPTH));
    assign w_empty   = (count_q == '0);
    // Pop from empty is ignored; a full FIFO still accepts a push if it pops.
    assign w_do_pop  = pop && !w_empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    assign empty    = w_empty;
    assign count    = count_q;
    assign overflow = push && !w_do_push;
    assign head     = w_empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: storage write, pointer advance and occupancy update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_wrlog.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wrlog
// Description : Word-addressed data RAM with combinational loads, clocked
//               stores, a store-log FIFO, saturating store counter and
//               sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wrlog
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int LOG_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [31:0]                dataadr,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic                       log_valid,
    output logic [31:0]                log_addr,
    output logic [31:0]                log_data,
    input  logic                       log_ready,
    output logic [$clog2(LOG_DEPTH):0] log_count,
    output logic [CNT_W-1:0]           wr_total,
    output logic                       log_overflow,
    output logic                       misalign_err,
    output logic                       range_err
);

    localparam int MA = $clog2(MEM_WORDS);

    logic [31:0]      ram_q [MEM_WORDS];
    logic [31:0]      ram_d [MEM_WORDS];
    logic [CNT_W-1:0] wr_total_q,     wr_total_d;
    logic             log_overflow_q, log_overflow_d;
    logic             misalign_err_q, misalign_err_d;
    logic             range_err_q,    range_err_d;

    logic             w_store_req;
    logic             w_aligned;
    logic             w_accept;
    logic             w_in_range;
    logic [MA-1:0]    w_word_idx;
    logic             w_fifo_empty;
    logic             w_fifo_ovf;
    log_entry_t       w_push_entry;
    log_entry_t       w_head;

    // Stores are ignored entirely while reset is high.
    assign w_store_req = memwrite && !reset;
    assign w_aligned   = is_aligned(dataadr);
    assign w_accept    = w_store_req && w_aligned;
    assign w_in_range  = (dataadr[31:MA+WORD_OFFSET_BITS] == '0);
    assign w_word_idx  = dataadr[MA+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

    // Load path reads the pre-edge word, so read-during-write returns old data.
    assign readdata = ram_q[w_word_idx];

    assign w_push_entry.addr = dataadr;
    assign w_push_entry.data = writedata;

    wrlog_fifo #(
        .DEPTH      (LOG_DEPTH)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .push       (w_accept),
        .push_entry (w_push_entry),
        .pop        (log_ready),
        .head       (w_head),
        .empty      (w_fifo_empty),
        .count      (log_count),
        .overflow   (w_fifo_ovf)
    );

    assign log_valid    = !w_fifo_empty;
    assign log_addr     = w_head.addr;
    assign log_data     = w_head.data;
    assign wr_total     = wr_total_q;
    assign log_overflow = log_overflow_q;
    assign misalign_err = misalign_err_q;
    assign range_err    = range_err_q;

    // RAM write only for accepted, in-range stores.
    always_comb begin
        ram_d = ram_q;
        if (w_accept && w_in_range) begin
            ram_d[w_word_idx] = writedata;
        end
    end

    // Counter saturates at all-ones; error flags are sticky until reset.
    always_comb begin
        wr_total_d     = wr_total_q;
        log_overflow_d = log_overflow_q | w_fifo_ovf;
        misalign_err_d = misalign_err_q | (w_store_req && !w_aligned);
        range_err_d    = range_err_q    | (w_accept && !w_in_range);
        if (w_accept && (wr_total_q != '1)) begin
            wr_total_d = wr_total_q + CNT_W'(1);
        end
    end

    // RAM storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        ram_q <= ram_d;
    end

    // Counter and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_total_q     <= '0;
            log_overflow_q <= 1'b0;
            misalign_err_q <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            wr_total_q     <= wr_total_d;
            log_overflow_q <= log_overflow_d;
            misalign_err_q <= misalign_err_d;
            range_err_q    <= range_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_wrlog.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_wrlog
// Description : Directed self-checking bench for dmem_wrlog. The counter is
//               built 4 bits wide so saturation is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_wrlog;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_ready;
    logic [3:0]  log_count;
    logic [3:0]  wr_total;
    logic        log_overflow;
    logic        misalign_err;
    logic        range_err;

    int errors = 0;
    int checks = 0;

    dmem_wrlog #(
        .MEM_WORDS    (64),
        .LOG_DEPTH    (8),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .readdata     (readdata),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_ready    (log_ready),
        .log_count    (log_count),
        .wr_total     (wr_total),
        .log_overflow (log_overflow),
        .misalign_err (misalign_err),
        .range_err    (range_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a store for one edge; memwrite stays high for back-to-back use.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 1'b0; log_ready = 1'b0;
        dataadr = 32'h0; writedata = 32'h0;
        step(); step();
        reset = 1'b0;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", log_valid); end
        checks++; if (log_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", log_count); end
        checks++; if (wr_total !== 4'd0) begin errors++; $display("FAIL rst_total got %0d want 0", wr_total); end
        checks++; if ({log_overflow, misalign_err, range_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {log_overflow, misalign_err, range_err}); end
        checks++; if ({log_addr, log_data} !== 64'h0) begin errors++; $display("FAIL rst_head got %h want 0", {log_addr, log_data}); end
    endtask

    task automatic test_store_basic();
        store(32'h50, 32'h7);
        store(32'h54, 32'h7);
        store(32'h58, 32'h32);
        memwrite = 1'b0;
        checks++; if (log_count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d want 3", log_count); end
        checks++; if (log_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h want 1", log_valid); end
        checks++; if (log_addr !== 32'h50 || log_data !== 32'h7) begin errors++; $display("FAIL basic_head got %h/%h want 50/7", log_addr, log_data); end
        checks++; if (wr_total !== 4'd3) begin errors++; $display("FAIL basic_total got %0d want 3", wr_total); end
        dataadr = 32'h50; #1;
        checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL basic_load50 got %h want 7", readdata); end
        dataadr = 32'h58; #1;
        checks++; if (readdata !== 32'h32) begin errors++; $display("FAIL basic_load58 got %h want 32", readdata); end
    endtask

    task automatic test_drain();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea[0] = 32'h50; ea[1] = 32'h54; ea[2] = 32'h58;
        ed[0] = 32'h7;  ed[1] = 32'h7;  ed[2] = 32'h32;
        log_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_valid !== 1'b1 || log_addr !== ea[i] || log_data !== ed[i]) begin
                errors++; $display("FAIL drain_%0d got v=%0h %h/%h want v=1 %h/%h", i, log_valid, log_addr, log_data, ea[i], ed[i]);
            end
            step();
        end
        checks++; if (log_valid !== 1'b0 || log_addr !== 32'h0 || log_data !== 32'h0) begin errors++; $display("FAIL drain_empty got v=%0h %h/%h want v=0 0/0", log_valid, log_addr, log_data); end
        step();
        checks++; if (log_count !== 4'd0) begin errors++; $display("FAIL drain_pop_empty got %0d want 0", log_count); end
        log_ready = 1'b0;
    endtask

    task automatic test_overflow();
        pulse_reset();
        for (int k = 0; k < 10; k++) store(32'h5c + 32'(4*k), 32'h17 + 32'(k));
        memwrite = 1'b0;
        checks++; if (log_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", log_count); end
        checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h want 1", log_overflow); end
        checks++; if (wr_total !== 4'd10) begin errors++; $display("FAIL ovf_total got %0d want 10", wr_total); end
        log_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (log_addr !== 32'h5c + 32'(4*k) || log_data !== 32'h17 + 32'(k)) begin
                errors++; $display("FAIL ovf_drain_%0d got %h/%h want %h/%h", k, log_addr, log_data, 32'h5c + 32'(4*k), 32'h17 + 32'(k));
            end
            step();
        end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0h want 0", log_valid); end
        log_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        pulse_reset();
        for (int k = 0; k < 8; k++) store(32'h80 + 32'(4*k), 32'h100 + 32'(k));
        memwrite = 1'b0;
        checks++; if (log_count !== 4'd8 || log_overflow !== 1'b0) begin errors++; $display("FAIL full_fill got %0d/%0h want 8/0", log_count, log_overflow); end
        log_ready = 1'b1;
        memwrite = 1'b1; dataadr = 32'h60; writedata = 32'h19;
        step();
        memwrite = 1'b0; log_ready = 1'b0;
        checks++; if (log_count !== 4'd8) begin errors++; $display("FAIL full_pp_count got %0d want 8", log_count); end
        checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL full_pp_ovf got %0h want 0", log_overflow); end
        checks++; if (log_addr !== 32'h84 || log_data !== 32'h101) begin errors++; $display("FAIL full_pp_head got %h/%h want 84/101", log_addr, log_data); end
        checks++; if (wr_total !== 4'd9) begin errors++; $display("FAIL full_pp_total got %0d want 9", wr_total); end
        log_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        checks++; if (log_count !== 4'd1 || log_addr !== 32'h60 || log_data !== 32'h19) begin errors++; $display("FAIL full_tail got %0d %h/%h want 1 60/19", log_count, log_addr, log_data); end
        step();
        log_ready = 1'b0;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0h want 0", log_valid); end
    endtask

    task automatic test_read_during_write();
        memwrite = 1'b1; dataadr = 32'h58; writedata = 32'h77;
        #1;
        checks++; if (readdata !== 32'h32) begin errors++; $display("FAIL rdw_old got %h want 32", readdata); end
        step();
        memwrite = 1'b0; #1;
        checks++; if (readdata !== 32'h77) begin errors++; $display("FAIL rdw_new got %h want 77", readdata); end
        log_ready = 1'b1; step(); log_ready = 1'b0;
    endtask

    task automatic test_misalign_range();
        store(32'h0, 32'h1234);
        memwrite = 1'b0;
        log_ready = 1'b1; step(); log_ready = 1'b0;
        checks++; if (wr_total !== 4'd11 || log_count !== 4'd0) begin errors++; $display("FAIL mr_pre got %0d/%0d want 11/0", wr_total, log_count); end
        store(32'h51, 32'hDEAD);
        memwrite = 1'b0;
        checks++; if (misalign_err !== 1'b1 || range_err !== 1'b0) begin errors++; $display("FAIL mis_flag got %0h/%0h want 1/0", misalign_err, range_err); end
        checks++; if (wr_total !== 4'd11 || log_count !== 4'd0) begin errors++; $display("FAIL mis_nolog got %0d/%0d want 11/0", wr_total, log_count); end
        dataadr = 32'h50; #1;
        checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL mis_ram got %h want 7", readdata); end
        store(32'h400, 32'hBEEF);
        memwrite = 1'b0;
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL rng_flag got %0h want 1", range_err); end
        checks++; if (log_count !== 4'd1 || log_addr !== 32'h400 || log_data !== 32'hBEEF) begin errors++; $display("FAIL rng_log got %0d %h/%h want 1 400/beef", log_count, log_addr, log_data); end
        checks++; if (wr_total !== 4'd12) begin errors++; $display("FAIL rng_total got %0d want 12", wr_total); end
        dataadr = 32'h0; #1;
        checks++; if (readdata !== 32'h1234) begin errors++; $display("FAIL rng_ram0 got %h want 1234", readdata); end
    endtask

    task automatic test_reset_mid_drain();
        store(32'h90, 32'hA);
        store(32'h94, 32'hB);
        memwrite = 1'b0;
        checks++; if (log_count !== 4'd3) begin errors++; $display("FAIL rmd_pre got %0d want 3", log_count); end
        log_ready = 1'b1; reset = 1'b1;
        memwrite = 1'b1; dataadr = 32'h50; writedata = 32'h9999;
        step();
        reset = 1'b0; memwrite = 1'b0; log_ready = 1'b0;
        checks++; if (log_valid !== 1'b0 || log_count !== 4'd0) begin errors++; $display("FAIL rmd_log got %0h/%0d want 0/0", log_valid, log_count); end
        checks++; if (wr_total !== 4'd0) begin errors++; $display("FAIL rmd_total got %0d want 0", wr_total); end
        checks++; if ({log_overflow, misalign_err, range_err} !== 3'b000) begin errors++; $display("FAIL rmd_flags got %b want 000", {log_overflow, misalign_err, range_err}); end
        #1;
        checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL rmd_ram got %h want 7", readdata); end
    endtask

    task automatic test_saturation();
        log_ready = 1'b1;
        for (int k = 0; k < 14; k++) store(32'hA0, 32'(k));
        checks++; if (wr_total !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", wr_total); end
        store(32'hA0, 32'h20);
        checks++; if (wr_total !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", wr_total); end
        store(32'hA0, 32'h21);
        memwrite = 1'b0;
        checks++; if (wr_total !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", wr_total); end
        checks++; if (log_overflow !== 1'b0 || log_count !== 4'd1 || log_data !== 32'h21) begin errors++; $display("FAIL sat_log got %0h/%0d/%h want 0/1/21", log_overflow, log_count, log_data); end
        log_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_basic();
        test_drain();
        test_overflow();
        test_full_push_pop();
        test_read_during_write();
        test_misalign_range();
        test_reset_mid_drain();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
